// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signals for alu_arbiter.
// The arbiter uses the slave modport; the requesters and the ALU use the master modport.
interface alu_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [3:0]      req0_op;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic            resp0_valid;
  logic            resp0_ready;
  logic [XLEN-1:0] resp0_result;

  logic            req1_valid;
  logic            req1_ready;
  logic [3:0]      req1_op;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic            resp1_valid;
  logic            resp1_ready;
  logic [XLEN-1:0] resp1_result;

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] alu_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, resp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, resp1_ready,
    input  alu_result,
    output req0_ready, resp0_valid, resp0_result,
    output req1_ready, resp1_valid, resp1_result,
    output alu_a, alu_b, alu_control
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, resp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, resp1_ready,
    output alu_result,
    input  req0_ready, resp0_valid, resp0_result,
    input  req1_ready, resp1_valid, resp1_result,
    input  alu_a, alu_b, alu_control
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the execute stage (port 0) and the branch/address unit (port 1).
// Define ALU_ARB_STATS_EN to add the grant_cnt0/grant_cnt1/conflict_cnt statistics outputs.
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1,
  output logic [31:0] conflict_cnt
`endif
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slotState_t;

  slotState_t      r_slot0;
  slotState_t      r_slot1;
  logic [XLEN-1:0] r_result0;
  logic [XLEN-1:0] r_result1;
  logic            r_rrPtr;

  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;

  // A full slot only blocks its port if the consumer is not draining it this cycle.
  assign w_elig0  = bus.req0_valid && ((r_slot0 == SLOT_EMPTY) || bus.resp0_ready);
  assign w_elig1  = bus.req1_valid && ((r_slot1 == SLOT_EMPTY) || bus.resp1_ready);
  assign w_grant0 = w_elig0 && (!w_elig1 || !r_rrPtr);
  assign w_grant1 = w_elig1 && (!w_elig0 ||  r_rrPtr);

  assign bus.req0_ready   = w_grant0;
  assign bus.req1_ready   = w_grant1;
  assign bus.resp0_valid  = (r_slot0 == SLOT_FULL);
  assign bus.resp1_valid  = (r_slot1 == SLOT_FULL);
  assign bus.resp0_result = r_result0;
  assign bus.resp1_result = r_result1;

  always_comb begin
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_control = 4'b0000;
    if (w_grant0) begin
      bus.alu_a       = bus.req0_a;
      bus.alu_b       = bus.req0_b;
      bus.alu_control = bus.req0_op;
    end else if (w_grant1) begin
      bus.alu_a       = bus.req1_a;
      bus.alu_b       = bus.req1_b;
      bus.alu_control = bus.req1_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot0   <= SLOT_EMPTY;
      r_slot1   <= SLOT_EMPTY;
      r_result0 <= '0;
      r_result1 <= '0;
      r_rrPtr   <= 1'b0;
    end else begin
      if (w_grant0) begin
        r_rrPtr <= 1'b1;
      end else if (w_grant1) begin
        r_rrPtr <= 1'b0;
      end

      // A grant reloads the slot even when it is drained in the same cycle.
      case (r_slot0)
        SLOT_EMPTY: if (w_grant0) r_slot0 <= SLOT_FULL;
        SLOT_FULL:  if (!w_grant0 && bus.resp0_ready) r_slot0 <= SLOT_EMPTY;
        default:    r_slot0 <= SLOT_EMPTY;
      endcase
      if (w_grant0) begin
        r_result0 <= bus.alu_result;
      end

      case (r_slot1)
        SLOT_EMPTY: if (w_grant1) r_slot1 <= SLOT_FULL;
        SLOT_FULL:  if (!w_grant1 && bus.resp1_ready) r_slot1 <= SLOT_EMPTY;
        default:    r_slot1 <= SLOT_EMPTY;
      endcase
      if (w_grant1) begin
        r_result1 <= bus.alu_result;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [31:0] r_grantCnt0;
  logic [31:0] r_grantCnt1;
  logic [31:0] r_conflictCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grantCnt0   <= '0;
      r_grantCnt1   <= '0;
      r_conflictCnt <= '0;
    end else begin
      if (w_grant0)           r_grantCnt0   <= r_grantCnt0 + 32'd1;
      if (w_grant1)           r_grantCnt1   <= r_grantCnt1 + 32'd1;
      if (w_elig0 && w_elig1) r_conflictCnt <= r_conflictCnt + 32'd1;
    end
  end

  assign grant_cnt0   = r_grantCnt0;
  assign grant_cnt1   = r_grantCnt1;
  assign conflict_cnt = r_conflictCnt;
`endif

endmodule
